mult_pipe: RTL and testbench

Parametrised, elastic, multi-stage integer multiplier for the EX stage of the pipelined RISC-V core. It supports RV64M MUL/MULH/MULHSU/MULHU and uses a valid/ready handshake on both sides. Each stage holds its own valid bit, so bubbles collapse under backpressure. A destination-register tag travels with each operation, and a flush input kills all in-flight work on a branch/jump redirect.

---
 rtl/mult_pipe.sv | 121 ++++++++++++
 tb/tb_mult_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe.sv
// Elastic multi-stage RV64M multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready on
// both sides, per-stage valid bits, a sideband tag and a pipeline flush.
module mult_pipe #(
    parameter int DATA_W = 64,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [1:0]        mode,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [TAG_W-1:0]  tag_out,
    output logic              busy
);

    localparam int LAST = STAGES - 1;

    typedef enum logic [1:0] {
        MODE_MUL    = 2'b00,
        MODE_MULH   = 2'b01,
        MODE_MULHSU = 2'b10,
        MODE_MULHU  = 2'b11
    } mode_e;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic [DATA_W-1:0] res_q [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];

    mode_e               op_mode;
    logic                sign_a;
    logic                sign_b;
    logic [2*DATA_W-1:0] a_wide;
    logic [2*DATA_W-1:0] b_wide;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   sel;
    logic                accept;

    // Extending both operands to 2*DATA_W makes the modulo-2^(2*DATA_W) product
    // exact for every signedness combination, so one unsigned multiplier serves
    // all four modes. Trailing stages leave room for retiming the multiplier.
    always_comb begin
        // NOTE: every variable in a combinational block is assigned on every path,
        // otherwise synthesis infers a latch to hold the old value.
        op_mode = mode_e'(mode);
        sign_a  = 1'b0;
        sign_b  = 1'b0;
        case (op_mode)
            MODE_MULH: begin
                sign_a = op_a[DATA_W-1];
                sign_b = op_b[DATA_W-1];
            end
            MODE_MULHSU: sign_a = op_a[DATA_W-1];
            default: ;
        endcase
        a_wide = {{DATA_W{sign_a}}, op_a};
        b_wide = {{DATA_W{sign_b}}, op_b};
        prod   = a_wide * b_wide;
        sel    = (op_mode == MODE_MUL) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
    end

    // A stage may move on when it is empty or everything downstream of it moves.
    always_comb begin
        logic room;
        room = out_ready;
        for (int i = LAST; i >= 0; i--) begin
            room   = room || !vld[i];
            adv[i] = room;
        end
    end

    assign in_ready  = !rst && !flush && adv[0];
    assign accept    = in_valid && in_ready;
    assign out_valid = vld[LAST] && !flush;
    assign result    = res_q[LAST];
    assign tag_out   = tag_q[LAST];
    assign busy      = |vld;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every stage
        // samples the pre-edge value of its neighbour.
        if (rst) begin
            vld <= '0;
            // NOTE: the data registers are cleared too, because result and tag_out
            // must read zero after reset; they are not left uninitialised.
            for (int i = 0; i < STAGES; i++) begin
                res_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            if (flush) begin
                vld <= '0;
            end else begin
                if (adv[0]) vld[0] <= accept;
                for (int i = 1; i < STAGES; i++) begin
                    if (adv[i]) vld[i] <= vld[i-1];
                end
            end
            if (accept) begin
                res_q[0] <= sel;
                tag_q[0] <= tag_in;
            end
            // Payload only moves with a valid op, so a stalled result stays put.
            for (int i = 1; i < STAGES; i++) begin
                if (adv[i] && vld[i-1]) begin
                    res_q[i] <= res_q[i-1];
                    tag_q[i] <= tag_q[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_pipe.sv
// Directed bench for mult_pipe: table-driven mode vectors plus hand-written
// streaming, backpressure, flush and reset sequences.
module tb_mult_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] op_a = '0;
    logic [63:0] op_b = '0;
    logic [1:0]  mode = 2'b00;
    logic [4:0]  tag_in = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic [4:0]  tag_out;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  tag;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [12];

    mult_pipe #(.DATA_W(64), .STAGES(3), .TAG_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mode      (mode),
        .tag_in    (tag_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .tag_out   (tag_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h, expected 0x%016h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single op with out_ready high: checks latency, value, tag and idle afterwards.
    task automatic do_op(input string nm, input logic [1:0] m, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] t, input logic [63:0] exp);
        int cyc;
        out_ready = 1'b1;
        mode      = m;
        op_a      = a;
        op_b      = b;
        tag_in    = t;
        in_valid  = 1'b1;
        #1;
        check({nm, " in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        check({nm, " latency"}, 64'(cyc), 64'd3);
        check({nm, " result"}, result, exp);
        check({nm, " tag"}, 64'(tag_out), 64'(t));
        tick();
        check({nm, " out_valid after"}, 64'(out_valid), 64'd0);
        check({nm, " busy after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int sent;
        int rcv;
        logic rdy;

        vecs[0]  = '{2'b00, 64'd3, 64'd5, 5'd7, 64'd15};
        vecs[1]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 64'd0};
        vecs[2]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 64'd1};
        vecs[3]  = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64'd1};
        vecs[4]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5]  = '{2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd5,
                     64'h4000_0000_0000_0000};
        vecs[6]  = '{2'b10, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'd1};
        vecs[7]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[8]  = '{2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd9,
                     64'h4000_0000_0000_0000};
        vecs[9]  = '{2'b00, 64'h1_0000_0000, 64'h1_0000_0000, 5'd10, 64'd0};
        vecs[10] = '{2'b11, 64'h1_0000_0000, 64'h1_0000_0000, 5'd11, 64'd1};
        vecs[11] = '{2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 5'd12,
                     64'h3FFF_FFFF_FFFF_FFFF};

        // Reset state while rst is held.
        tick();
        tick();
        check("rst in_ready", 64'(in_ready), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst result", result, 64'd0);
        check("rst tag_out", 64'(tag_out), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        check("post-rst in_ready", 64'(in_ready), 64'd1);

        // Mode vectors.
        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].a, vecs[i].b,
                  vecs[i].tag, vecs[i].exp);
        end

        // Back-to-back stream of 10 ops.
        out_ready = 1'b1;
        mode      = 2'b00;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 10);
            op_a     = 64'(c);
            op_b     = 64'(c + 1);
            tag_in   = 5'(c);
            #1;
            if (c < 10) check($sformatf("stream c%0d in_ready", c), 64'(in_ready), 64'd1);
            check($sformatf("stream c%0d out_valid", c), 64'(out_valid),
                  64'((c >= 3 && c <= 12) ? 1 : 0));
            if (c >= 3 && c <= 12) begin
                check($sformatf("stream c%0d result", c), result, 64'((c - 3) * (c - 2)));
                check($sformatf("stream c%0d tag", c), 64'(tag_out), 64'(c - 3));
            end
            tick();
        end

        // Backpressure: 6 ops, consumer stalled for the first 6 cycles.
        sent = 0;
        rcv  = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = (c >= 6);
            in_valid  = (sent < 6);
            op_a      = 64'(sent + 2);
            op_b      = 64'd3;
            tag_in    = 5'(sent + 10);
            #1;
            if (c >= 3 && c <= 5) begin
                check($sformatf("bp c%0d in_ready", c), 64'(in_ready), 64'd0);
                check($sformatf("bp c%0d out_valid", c), 64'(out_valid), 64'd1);
                check($sformatf("bp c%0d held result", c), result, 64'd6);
                check($sformatf("bp c%0d held tag", c), 64'(tag_out), 64'd10);
                check($sformatf("bp c%0d accepted", c), 64'(sent), 64'd3);
            end
            if (c == 6) check("bp full+out_ready in_ready", 64'(in_ready), 64'd1);
            rdy = in_ready;
            if (out_valid && out_ready) begin
                check($sformatf("bp out%0d result", rcv), result, 64'(3 * rcv + 6));
                check($sformatf("bp out%0d tag", rcv), 64'(tag_out), 64'(rcv + 10));
                rcv++;
            end
            tick();
            if (in_valid && rdy) sent++;
        end
        in_valid = 1'b0;
        check("bp delivered count", 64'(rcv), 64'd6);
        check("bp accepted count", 64'(sent), 64'd6);
        check("bp busy after", 64'(busy), 64'd0);

        // Flush with two ops in flight, one of them on the output.
        out_ready = 1'b1;
        mode      = 2'b00;
        in_valid  = 1'b1; op_a = 64'd5; op_b = 64'd5; tag_in = 5'd20;
        tick();
        op_a = 64'd6; op_b = 64'd6; tag_in = 5'd21;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; op_a = 64'd9; op_b = 64'd9; tag_in = 5'd22; flush = 1'b1;
        #1;
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush in_ready", 64'(in_ready), 64'd0);
        check("flush busy before edge", 64'(busy), 64'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post-flush busy", 64'(busy), 64'd0);
        check("post-flush out_valid", 64'(out_valid), 64'd0);
        check("post-flush in_ready", 64'(in_ready), 64'd1);
        do_op("post-flush op", 2'b00, 64'd4, 64'd4, 5'd9, 64'd16);

        // Reset with three ops in flight and the consumer stalled.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            op_a     = 64'(k + 1);
            op_b     = 64'd7;
            tag_in   = 5'(k + 1);
            tick();
        end
        in_valid = 1'b0;
        check("pre-rst out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("mid-rst in_ready", 64'(in_ready), 64'd0);
        tick();
        check("mid-rst out_valid", 64'(out_valid), 64'd0);
        check("mid-rst result", result, 64'd0);
        check("mid-rst tag_out", 64'(tag_out), 64'd0);
        check("mid-rst busy", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        check("after mid-rst in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("no stale c%0d", c), 64'(out_valid), 64'd0);
        end
        do_op("post-rst op", 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              5'd31, 64'hFFFF_FFFF_FFFF_FFFE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
